// File: rtl/entrada_digitos_rgb_pkg.sv
// ---------------------------------------------------------------------------
// entrada_rgb_pkg
// Shared definitions for the keypad-entry buffer: key codes, FSM state
// encoding and width helpers used by the interface, the serial BCD
// converter and the top level.
// ---------------------------------------------------------------------------
package entrada_rgb_pkg;

    localparam logic [4:0] COD_BORRAR  = 5'd10;
    localparam logic [4:0] COD_ENTER   = 5'd11;
    localparam logic [4:0] COD_LIMPIAR = 5'd12;
    localparam logic [4:0] COD_BLANCO  = 5'd16;

    typedef enum logic [1:0] {
        CARGA,
        CONVERTIR,
        COMPLETO
    } estado_t;

    // Bits needed to hold 10^nDigitos - 1. 10^n is never a power of two,
    // so clog2(10^n) always covers the largest n-digit number.
    function automatic int accWidth(input int nDigitos);
        int limite;
        limite = 1;
        for (int i = 0; i < nDigitos; i++) begin
            limite = limite * 10;
        end
        return $clog2(limite);
    endfunction

    // Index/counter width that never collapses to zero bits.
    function automatic int fieldWidth(input int nValores);
        return (nValores > 1) ? $clog2(nValores) : 1;
    endfunction

endpackage

// File: rtl/entrada_digitos_rgb_if.sv
// ---------------------------------------------------------------------------
// entrada_digitos_rgb_if
// Bundles the keypad-side inputs and the display/PWM-side outputs of the
// entry buffer.
//   digito        key code (0-9 digit, 10 BORRAR, 11 ENTER, 12 LIMPIAR)
//   cambio_digito one-cycle strobe qualifying digito
//   digitos       display buffer, 5 bits per slot, slot 0 = units
//   cont          number of digits held
//   canal         channel currently being entered
//   valores       confirmed values, channel 0 in the LSBs
//   ocupado       conversion in progress
//   error         one-cycle overflow pulse
//   listo         one-cycle pulse when the last channel is stored
// master: keypad/consumer side. slave: the entry buffer.
// ---------------------------------------------------------------------------
interface entrada_digitos_rgb_if
    import entrada_rgb_pkg::*;
#(
    parameter int N_CANALES = 3,
    parameter int N_DIGITOS = 3,
    parameter int VALOR_W   = 8
);
    localparam int CONT_W  = fieldWidth(N_DIGITOS + 1);
    localparam int CANAL_W = fieldWidth(N_CANALES);

    logic [4:0]                     digito;
    logic                           cambio_digito;
    logic [5*N_DIGITOS-1:0]         digitos;
    logic [CONT_W-1:0]              cont;
    logic [CANAL_W-1:0]             canal;
    logic [VALOR_W*N_CANALES-1:0]   valores;
    logic                           ocupado;
    logic                           error;
    logic                           listo;

    modport master (
        output digito, cambio_digito,
        input  digitos, cont, canal, valores, ocupado, error, listo
    );

    modport slave (
        input  digito, cambio_digito,
        output digitos, cont, canal, valores, ocupado, error, listo
    );

endinterface

// File: rtl/entrada_digitos_rgb_conv.sv
// ---------------------------------------------------------------------------
// bcd_a_binario_serie
// Serial decimal-to-binary converter: one BCD slot per cycle, most
// significant first, acc = acc*10 + d. Blank slots (any code above 9)
// leave the accumulator alone, so leading blanks are harmless.
//   clk, rst   clock, synchronous active-high reset
//   i_start    load acc = 0 and idx = N_DIGITOS-1, begin converting
//   i_digito   slot selected by o_idx (the digit stream)
//   o_idx      slot the converter wants this cycle
//   o_done     high during the cycle of the last slot
//   o_result   accumulator including the current slot; final when o_done
// ---------------------------------------------------------------------------
module bcd_a_binario_serie
    import entrada_rgb_pkg::*;
#(
    parameter int N_DIGITOS = 3,
    localparam int ACC_W    = accWidth(N_DIGITOS),
    localparam int IDX_W    = fieldWidth(N_DIGITOS)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [4:0]       i_digito,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_done,
    output logic [ACC_W-1:0] o_result
);

    logic [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic [ACC_W-1:0] w_accNext;

    // Next accumulator value for the slot being presented. Exposed directly
    // so the owner can store the final result on the same edge as the last
    // slot instead of waiting an extra cycle.
    always_comb begin
        w_accNext = r_acc;
        if (i_digito <= 5'd9) begin
            w_accNext = (r_acc * ACC_W'(10)) + ACC_W'(i_digito);
        end
    end

    // Walk the slots from the top down; busy drops after the units slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_acc  <= '0;
            r_idx  <= IDX_W'(N_DIGITOS - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_accNext;
            if (r_idx == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign o_idx    = r_idx;
    assign o_done   = r_busy && (r_idx == '0);
    assign o_result = w_accNext;

endmodule

// File: rtl/entrada_digitos_rgb.sv
// ---------------------------------------------------------------------------
// entrada_digitos_rgb
// Keypad-entry buffer for N_CANALES colour channels of up to N_DIGITOS
// decimal digits each. Digits shift in at the units slot; BORRAR removes
// the last digit, LIMPIAR blanks the entry, ENTER converts the entry to
// binary (N_DIGITOS cycles) and stores it for the current channel.
//   clk, rst   clock, synchronous active-high reset (highest priority)
//   bus        entrada_digitos_rgb_if.slave (see interface for signals)
// Build option SATURACION_EN: an overflowing entry stores VALOR_MAX and
// advances; without it the entry is discarded and the channel re-entered.
// Both variants pulse error on overflow.
// ---------------------------------------------------------------------------
module entrada_digitos_rgb
    import entrada_rgb_pkg::*;
#(
    parameter int N_CANALES = 3,
    parameter int N_DIGITOS = 3,
    parameter int VALOR_W   = 8,
    parameter int VALOR_MAX = 255
)(
    input  logic                  clk,
    input  logic                  rst,
    entrada_digitos_rgb_if.slave  bus
);

    localparam int CONT_W  = fieldWidth(N_DIGITOS + 1);
    localparam int CANAL_W = fieldWidth(N_CANALES);
    localparam int IDX_W   = fieldWidth(N_DIGITOS);
    localparam int ACC_W   = accWidth(N_DIGITOS);

    estado_t             r_estado;
    logic [4:0]          r_digitos [N_DIGITOS];
    logic [CONT_W-1:0]   r_cont;
    logic [CANAL_W-1:0]  r_canal;
    logic [VALOR_W-1:0]  r_valores [N_CANALES];
    logic                r_ocupado;
    logic                r_error;
    logic                r_listo;

    logic                w_start;
    logic [IDX_W-1:0]    w_idx;
    logic                w_done;
    logic [ACC_W-1:0]    w_result;
    logic                w_overflow;
    logic                w_avanza;
    logic [VALOR_W-1:0]  w_valorGuardar;

    // ENTER is honoured only while loading and with at least one digit.
    assign w_start = (r_estado == CARGA) && bus.cambio_digito &&
                     (bus.digito == COD_ENTER) && (r_cont != '0);

    bcd_a_binario_serie #(
        .N_DIGITOS (N_DIGITOS)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_digito (r_digitos[w_idx]),
        .o_idx    (w_idx),
        .o_done   (w_done),
        .o_result (w_result)
    );

    assign w_overflow = int'(w_result) > VALOR_MAX;

    // What happens to an overflowing entry depends on the build: either it
    // is clamped and treated as legal, or it is thrown away.
`ifdef SATURACION_EN
    assign w_avanza       = 1'b1;
    assign w_valorGuardar = w_overflow ? VALOR_W'(VALOR_MAX) : VALOR_W'(w_result);
`else
    assign w_avanza       = !w_overflow;
    assign w_valorGuardar = VALOR_W'(w_result);
`endif

    // Main FSM. All outputs are registered here; error and listo default to
    // zero every cycle so they come out as single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= CARGA;
            r_cont    <= '0;
            r_canal   <= '0;
            r_ocupado <= 1'b0;
            r_error   <= 1'b0;
            r_listo   <= 1'b0;
            for (int i = 0; i < N_DIGITOS; i++) r_digitos[i] <= COD_BLANCO;
            for (int c = 0; c < N_CANALES; c++) r_valores[c] <= '0;
        end else begin
            r_error <= 1'b0;
            r_listo <= 1'b0;
            case (r_estado)
                CARGA: begin
                    if (bus.cambio_digito) begin
                        if (bus.digito <= 5'd9) begin
                            if (r_cont < CONT_W'(N_DIGITOS)) begin
                                for (int i = N_DIGITOS - 1; i > 0; i--) begin
                                    r_digitos[i] <= r_digitos[i-1];
                                end
                                r_digitos[0] <= bus.digito;
                                r_cont       <= r_cont + CONT_W'(1);
                            end
                        end else if (bus.digito == COD_BORRAR) begin
                            if (r_cont != '0) begin
                                for (int i = 0; i < N_DIGITOS - 1; i++) begin
                                    r_digitos[i] <= r_digitos[i+1];
                                end
                                r_digitos[N_DIGITOS-1] <= COD_BLANCO;
                                r_cont <= r_cont - CONT_W'(1);
                            end
                        end else if (bus.digito == COD_LIMPIAR) begin
                            for (int i = 0; i < N_DIGITOS; i++) r_digitos[i] <= COD_BLANCO;
                            r_cont <= '0;
                        end else if (w_start) begin
                            r_estado  <= CONVERTIR;
                            r_ocupado <= 1'b1;
                        end
                    end
                end

                CONVERTIR: begin
                    // Keys are dropped here; only the converter's last slot matters.
                    if (w_done) begin
                        r_ocupado <= 1'b0;
                        r_error   <= w_overflow;
                        r_cont    <= '0;
                        for (int i = 0; i < N_DIGITOS; i++) r_digitos[i] <= COD_BLANCO;
                        if (w_avanza) begin
                            r_valores[r_canal] <= w_valorGuardar;
                            if (r_canal == CANAL_W'(N_CANALES - 1)) begin
                                r_listo  <= 1'b1;
                                r_estado <= COMPLETO;
                            end else begin
                                r_canal  <= r_canal + CANAL_W'(1);
                                r_estado <= CARGA;
                            end
                        end else begin
                            r_estado <= CARGA;
                        end
                    end
                end

                COMPLETO: begin
                    if (bus.cambio_digito && (bus.digito == COD_LIMPIAR)) begin
                        r_canal  <= '0;
                        r_cont   <= '0;
                        r_estado <= CARGA;
                        for (int i = 0; i < N_DIGITOS; i++) r_digitos[i] <= COD_BLANCO;
                        for (int c = 0; c < N_CANALES; c++) r_valores[c] <= '0;
                    end
                end

                default: r_estado <= CARGA;
            endcase
        end
    end

    // Flatten the slot and channel arrays onto the interface buses.
    for (genvar g = 0; g < N_DIGITOS; g++) begin : g_digitos
        assign bus.digitos[5*g +: 5] = r_digitos[g];
    end

    for (genvar g = 0; g < N_CANALES; g++) begin : g_valores
        assign bus.valores[VALOR_W*g +: VALOR_W] = r_valores[g];
    end

    assign bus.cont    = r_cont;
    assign bus.canal   = r_canal;
    assign bus.ocupado = r_ocupado;
    assign bus.error   = r_error;
    assign bus.listo   = r_listo;

endmodule

// File: doc/entrada_digitos_rgb.md
Name: entrada_digitos_rgb

Overview:
- Parametrised keypad-entry buffer. Collects decimal digits for N_CANALES colour channels (default R, G, B), each up to N_DIGITOS digits.
- Supports backspace, clear and enter codes. Converts each confirmed entry to binary over N_DIGITOS cycles and stores it per channel.
- Sits between the keypad decoder (digit code plus one-cycle strobe) and the RGB/PWM and display blocks.

Parameters:
- N_CANALES, 3: number of channels entered in sequence (channel 0 first).
- N_DIGITOS, 3: maximum digits per entry.
- VALOR_W, 8: width of each stored binary value.
- VALOR_MAX, 255: largest legal value per channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- digito  in  5  key code: 0–9 digit, 10 BORRAR, 11 ENTER, 12 LIMPIAR; all other codes are ignored.
- cambio_digito  in  1  one-cycle strobe; digito is valid in that cycle.
- digitos  out  5*N_DIGITOS  display buffer for the current channel. Slot 0 is the units digit. Empty slots hold 16 (blank).
- cont  out  clog2(N_DIGITOS+1)  number of digits currently held.
- canal  out  clog2(N_CANALES)  channel being entered.
- valores  out  VALOR_W*N_CANALES  confirmed values; channel 0 is in the LSBs.
- ocupado  out  1  high while in CONVERTIR.
- error  out  1  one-cycle pulse on overflow.
- listo  out  1  one-cycle pulse when the last channel is stored.

Behaviour:
- Reset values: all digit slots = 16, cont = 0, canal = 0, valores = 0, ocupado/error/listo = 0, state = CARGA.
- rst has priority over everything. Asserted mid-conversion, it aborts the conversion; nothing is stored.
- Key events are sampled only when cambio_digito = 1.

State CARGA:
- Digit 0–9 with cont < N_DIGITOS: shift the buffer up one slot, place the new digit in slot 0, cont + 1. Visible the next cycle.
- Digit with cont == N_DIGITOS: ignored. The buffer is unchanged.
- BORRAR with cont > 0: shift down one slot, top slot = 16, cont − 1.
- BORRAR with cont == 0: no-op.
- LIMPIAR: all slots = 16, cont = 0. canal and valores are unchanged.
- ENTER with cont == 0: ignored.
- ENTER with cont > 0: load acc = 0 and idx = N_DIGITOS − 1, go to CONVERTIR.

State CONVERTIR:
- ocupado = 1. Takes exactly N_DIGITOS cycles, one slot per cycle, most significant first.
- Per slot: a blank slot leaves acc unchanged; a digit slot sets acc = acc*10 + d.
- acc width is ACC_W, sized to hold 10^N_DIGITOS − 1 without wrap.
- All key events in this state are dropped, including LIMPIAR.
- After the last slot, in the same clock edge:
  - acc ≤ VALOR_MAX: valores[canal] = acc[VALOR_W−1:0], buffer cleared, cont = 0.
  - If canal == N_CANALES − 1: listo pulses, go to COMPLETO.
  - Otherwise canal + 1, return to CARGA.
  - acc > VALOR_MAX: see Optional Feature.

State COMPLETO:
- valores hold.
- LIMPIAR: canal = 0, valores = 0, buffer cleared, return to CARGA.
- All other keys are ignored.

Optional Feature:
- Macro: SATURACION_EN.
- Defined: on overflow, store VALOR_MAX, pulse error, then advance exactly as for a legal value.
- Not defined: on overflow, pulse error, store nothing, clear the buffer, stay on the same canal, return to CARGA.

Decomposition:
- Package entrada_rgb_pkg holds:
  - Key-code constants: COD_BORRAR = 10, COD_ENTER = 11, COD_LIMPIAR = 12, COD_BLANCO = 16.
  - State encoding: CARGA, CONVERTIR, COMPLETO.
  - An ACC_W function of N_DIGITOS.
- One natural sub-module: bcd_a_binario_serie, the sequential multiply-by-10-and-add converter. Interface: start, digit stream, done, result.

Test Plan:
- Reset, then keys 1, 2, 8 -> digitos = {1,2,8} with units digit 8; cont = 3. A 4th key (5) is ignored.
- Keys 1, 2, BORRAR -> slot 0 = 1, slot 1 = 16, cont = 1. ENTER -> ocupado high 3 cycles, valores[0] = 1, canal = 1.
- Enter 255, 0, 7 with ENTER after each -> valores = {7, 0, 255}. listo pulses once; a following key 3 is ignored.
- Enter 300 then ENTER:
  - Without SATURACION_EN -> error pulse, canal stays 0, valores[0] = 0.
  - With SATURACION_EN -> error pulse, valores[0] = 255, canal = 1.
- Enter 9, ENTER, then key 4 strobed during CONVERTIR -> 4 is dropped; stored value = 9; the buffer is blank afterwards.
- Start a conversion of 12, assert rst on its 2nd cycle -> all outputs return to reset values; valores[0] = 0.
